// File: rtl/calc_input_sequencer_pkg.sv
// rtl/calc_input_sequencer_pkg.sv - shared state, opcode and event types for the calculator entry controller
//
// Purpose: FSM state encoding and opcode encoding shared with the ALU and
// the display, the per-cycle button event bundle, and the priority
// arbiter that picks one winner among simultaneous events.
// Ports:   none (package)
package calc_input_sequencer_pkg;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_RDY  = 3'd2,
        S_BUSY = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } opcode_t;

    typedef struct packed {
        logic clr;
        logic eq;
        logic load;
    } btn_ev_t;

    // clr beats eq beats load; losers are simply dropped.
    function automatic btn_ev_t arbitrate(btn_ev_t raw);
        btn_ev_t win;
        win.clr  = raw.clr;
        win.eq   = raw.eq & ~raw.clr;
        win.load = raw.load & ~raw.eq & ~raw.clr;
        return win;
    endfunction

endpackage

// File: rtl/calc_input_sequencer_btn_edge_sync.sv
// rtl/calc_input_sequencer_btn_edge_sync.sv - button synchroniser with registered rising-edge pulse
//
// Purpose: brings one raw asynchronous push-button into the clk domain
// through two flops, then emits a single-cycle pulse on each rising
// edge regardless of how long the button is held.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset; clears every flop and the pulse
//   btn_i  raw asynchronous button level
//   ev_o   one-cycle event pulse, high two edges after btn_i is first sampled high
module btn_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic ev_o
);

    logic s1_q;
    logic s2_q;
    logic d_q;
    logic ev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            d_q  <= 1'b0;
            ev_q <= 1'b0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
            d_q  <= s2_q;
            ev_q <= s2_q & ~d_q;
        end
    end

    assign ev_o = ev_q;

endmodule

// File: rtl/calc_input_sequencer.sv
// rtl/calc_input_sequencer.sv - operand/operator entry controller feeding the calculator ALU
//
// Purpose: turns three push-buttons into load/eq/clr events, arbitrates
// them, sequences operand A, operand B and opcode capture, pulses start
// to the ALU and waits for alu_done with a timeout.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   btn_load_i  raw button: capture sw_i as the next operand
//   btn_eq_i    raw button: execute
//   btn_clr_i   raw button: clear entry
//   sw_i        operand switches
//   op_sel_i    opcode switches, captured together with operand B
//   alu_done_i  one-cycle result-valid pulse from the ALU
//   op_a_o      operand A register
//   op_b_o      operand B register
//   op_code_o   latched opcode
//   start_o     one-cycle start pulse to the ALU
//   busy_o      high while waiting for the ALU
//   err_o       sticky timeout flag
//   state_o     current FSM state for display/debug
module calc_input_sequencer
    import calc_input_sequencer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             btn_load_i,
    input  logic             btn_eq_i,
    input  logic             btn_clr_i,
    input  logic [WIDTH-1:0] sw_i,
    input  logic [1:0]       op_sel_i,
    input  logic             alu_done_i,
    output logic [WIDTH-1:0] op_a_o,
    output logic [WIDTH-1:0] op_b_o,
    output logic [1:0]       op_code_o,
    output logic             start_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [2:0]       state_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Counter starts at 0 in the first BUSY cycle, so the last allowed
    // cycle (the TIMEOUT-th) is the one where it holds TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    btn_ev_t raw_ev;
    btn_ev_t ev;

    btn_edge_sync u_sync_load (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .btn_i (btn_load_i),
        .ev_o  (raw_ev.load)
    );

    btn_edge_sync u_sync_eq (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .btn_i (btn_eq_i),
        .ev_o  (raw_ev.eq)
    );

    btn_edge_sync u_sync_clr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .btn_i (btn_clr_i),
        .ev_o  (raw_ev.clr)
    );

    assign ev = arbitrate(raw_ev);

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] op_a_q,     op_a_d;
    logic [WIDTH-1:0] op_b_q,     op_b_d;
    opcode_t          op_code_q,  op_code_d;
    logic             err_q,      err_d;
    logic             start_q,    start_d;
    logic             clr_pend_q, clr_pend_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             exit_busy;
    logic             timed_out;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_code_q  <= OP_ADD;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            clr_pend_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_code_q  <= op_code_d;
            err_q      <= err_d;
            start_q    <= start_d;
            clr_pend_q <= clr_pend_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_code_d  = op_code_q;
        err_d      = err_q;
        start_d    = 1'b0;
        clr_pend_d = clr_pend_q;
        cnt_d      = cnt_q;
        exit_busy  = 1'b0;
        timed_out  = 1'b0;

        case (state_q)
            S_A: begin
                if (ev.clr) begin
                    op_a_d    = '0;
                    op_b_d    = '0;
                    op_code_d = OP_ADD;
                    err_d     = 1'b0;
                end else if (ev.load) begin
                    op_a_d  = sw_i;
                    state_d = S_B;
                end
            end

            S_B: begin
                if (ev.clr) begin
                    op_a_d    = '0;
                    op_b_d    = '0;
                    op_code_d = OP_ADD;
                    err_d     = 1'b0;
                    state_d   = S_A;
                end else if (ev.load) begin
                    op_b_d    = sw_i;
                    op_code_d = opcode_t'(op_sel_i);
                    state_d   = S_RDY;
                end
            end

            S_RDY: begin
                if (ev.clr) begin
                    op_a_d    = '0;
                    op_b_d    = '0;
                    op_code_d = OP_ADD;
                    err_d     = 1'b0;
                    state_d   = S_A;
                end else if (ev.eq) begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                // done takes precedence over a timeout landing in the same cycle
                if (alu_done_i) begin
                    exit_busy = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    exit_busy = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end

                if (exit_busy) begin
                    // A clear seen while busy (including this very cycle)
                    // redirects the exit to S_A, but a timeout still flags.
                    if (clr_pend_q || ev.clr) begin
                        op_a_d    = '0;
                        op_b_d    = '0;
                        op_code_d = OP_ADD;
                        err_d     = timed_out;
                        state_d   = S_A;
                    end else begin
                        err_d   = err_q | timed_out;
                        state_d = S_SHOW;
                    end
                    clr_pend_d = 1'b0;
                end else if (ev.clr) begin
                    clr_pend_d = 1'b1;
                end
            end

            S_SHOW: begin
                if (ev.clr) begin
                    op_a_d    = '0;
                    op_b_d    = '0;
                    op_code_d = OP_ADD;
                    err_d     = 1'b0;
                    state_d   = S_A;
                end else if (ev.load) begin
                    op_a_d  = sw_i;
                    err_d   = 1'b0;
                    state_d = S_B;
                end
            end

            default: begin
                state_d = S_A;
            end
        endcase
    end

    assign op_a_o    = op_a_q;
    assign op_b_o    = op_b_q;
    assign op_code_o = op_code_q;
    assign start_o   = start_q;
    assign busy_o    = (state_q == S_BUSY);
    assign err_o     = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// tb/tb_calc_input_sequencer.sv - self-checking bench for calc_input_sequencer
module tb_calc_input_sequencer;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             btn_load;
    logic             btn_eq;
    logic             btn_clr;
    logic [WIDTH-1:0] sw;
    logic [1:0]       op_sel;
    logic             alu_done;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_code;
    logic             start;
    logic             busy;
    logic             err;
    logic [2:0]       state;

    always #5 clk = ~clk;

    calc_input_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .btn_load_i (btn_load),
        .btn_eq_i   (btn_eq),
        .btn_clr_i  (btn_clr),
        .sw_i       (sw),
        .op_sel_i   (op_sel),
        .alu_done_i (alu_done),
        .op_a_o     (op_a),
        .op_b_o     (op_b),
        .op_code_o  (op_code),
        .start_o    (start),
        .busy_o     (busy),
        .err_o      (err),
        .state_o    (state)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: a press becomes an action three edges after the
    // button is first seen high (reset cancels anything in flight and
    // forgets the previous level); then the entry rules are applied.
    int  cyc = 0;
    int  due_l[$];
    int  due_e[$];
    int  due_c[$];
    bit  prev_l, prev_e, prev_c;
    int  m_state, m_a, m_b, m_op, m_err, m_start, m_pend, m_busy_n;
    bit  m_valid = 1'b0;

    always @(posedge clk) begin
        bit fl, fe, fc, done_now, tmo;
        cyc++;
        if (rst) begin
            due_l.delete(); due_e.delete(); due_c.delete();
            prev_l = 0; prev_e = 0; prev_c = 0;
            m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_err = 0;
            m_start = 0; m_pend = 0; m_busy_n = 0;
            m_valid = 1'b1;
        end else begin
            fl = (due_l.size() > 0 && due_l[0] == cyc); if (fl) void'(due_l.pop_front());
            fe = (due_e.size() > 0 && due_e[0] == cyc); if (fe) void'(due_e.pop_front());
            fc = (due_c.size() > 0 && due_c[0] == cyc); if (fc) void'(due_c.pop_front());
            if (btn_load && !prev_l) due_l.push_back(cyc + 3);
            if (btn_eq   && !prev_e) due_e.push_back(cyc + 3);
            if (btn_clr  && !prev_c) due_c.push_back(cyc + 3);
            prev_l = btn_load; prev_e = btn_eq; prev_c = btn_clr;
            if (fc) begin fe = 0; fl = 0; end
            if (fe) fl = 0;
            m_start = 0;
            if (m_state == 3) begin
                if (fc) m_pend = 1;
                done_now = alu_done;
                tmo = 0;
                if (!done_now) begin
                    m_busy_n++;
                    tmo = (m_busy_n == TIMEOUT);
                end
                if (done_now || tmo) begin
                    if (m_pend) begin
                        m_a = 0; m_b = 0; m_op = 0; m_err = tmo; m_state = 0;
                    end else begin
                        if (tmo) m_err = 1;
                        m_state = 4;
                    end
                    m_pend = 0;
                end
            end else if (fc) begin
                m_a = 0; m_b = 0; m_op = 0; m_err = 0; m_state = 0;
            end else begin
                case (m_state)
                    0: if (fl) begin m_a = sw; m_state = 1; end
                    1: if (fl) begin m_b = sw; m_op = op_sel; m_state = 2; end
                    2: if (fe) begin m_start = 1; m_busy_n = 0; m_state = 3; end
                    4: if (fl) begin m_a = sw; m_err = 0; m_state = 1; end
                    default: m_state = 0;
                endcase
            end
        end
    end

    int start_cnt = 0;
    int busy_cnt  = 0;

    always @(negedge clk) begin
        if (start) start_cnt++;
        if (busy)  busy_cnt++;
        if (m_valid) begin
            chk("state",   state,   m_state);
            chk("op_a",    op_a,    m_a);
            chk("op_b",    op_b,    m_b);
            chk("op_code", op_code, m_op);
            chk("err",     err,     m_err);
            chk("start",   start,   m_start);
            chk("busy",    busy,    (m_state == 3) ? 1 : 0);
        end
    end

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_load = v;
            1: btn_eq   = v;
            default: btn_clr = v;
        endcase
    endtask

    task automatic press(input int which, input int hold);
        @(negedge clk);
        set_btn(which, 1'b1);
        repeat (hold) @(negedge clk);
        set_btn(which, 1'b0);
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_busy();
        int i = 0;
        while (!busy && i < 30) begin
            @(negedge clk);
            i++;
        end
        chk("wait_busy", busy, 1);
    endtask

    task automatic load_pair(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
        sw = a;
        press(0, 1);
        sw = b; op_sel = o;
        press(0, 1);
    endtask

    initial begin
        rst = 1'b1; btn_load = 0; btn_eq = 0; btn_clr = 0;
        sw = '0; op_sel = '0; alu_done = 0;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_op_a",  op_a,  0);
        chk("rst_start", start, 0);
        chk("rst_busy",  busy,  0);
        chk("rst_err",   err,   0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic sequence, done in the fifth busy cycle
        load_pair(8'h12, 8'h34, 2'b01);
        start_cnt = 0; busy_cnt = 0;
        @(negedge clk); btn_eq = 1;
        @(negedge clk); btn_eq = 0;
        wait_busy();
        repeat (4) @(negedge clk);
        alu_done = 1;
        @(negedge clk); alu_done = 0;
        repeat (3) @(negedge clk);
        chk("t1_op_a", op_a, 8'h12);
        chk("t1_op_b", op_b, 8'h34);
        chk("t1_op_code", op_code, 1);
        chk("t1_starts", start_cnt, 1);
        chk("t1_busy_cycles", busy_cnt, 5);
        chk("t1_state", state, 4);
        chk("t1_err", err, 0);

        // long press captures once
        press(2, 1);
        sw = 8'h5A;
        @(negedge clk); btn_load = 1;
        repeat (10) @(negedge clk);
        sw = 8'hA5;
        repeat (40) @(negedge clk);
        btn_load = 0;
        repeat (5) @(negedge clk);
        chk("t2_state", state, 1);
        chk("t2_op_a", op_a, 8'h5A);
        chk("t2_op_b", op_b, 0);

        // clr and load together in S_B
        press(2, 1);
        sw = 8'h12; press(0, 1);
        sw = 8'h99;
        @(negedge clk); btn_clr = 1; btn_load = 1;
        repeat (2) @(negedge clk);
        btn_clr = 0; btn_load = 0;
        repeat (5) @(negedge clk);
        chk("t3_state", state, 0);
        chk("t3_op_a", op_a, 0);

        // timeout, then a load in SHOW clears err
        load_pair(8'h21, 8'h03, 2'b10);
        busy_cnt = 0;
        press(1, 1);
        repeat (25) @(negedge clk);
        chk("t4_busy_cycles", busy_cnt, 10);
        chk("t4_err", err, 1);
        chk("t4_state", state, 4);
        sw = 8'h77; press(0, 1);
        chk("t4_err_cleared", err, 0);
        chk("t4_state_b", state, 1);
        chk("t4_op_a", op_a, 8'h77);

        // done in the same cycle the timeout would fire
        sw = 8'h08; op_sel = 2'b11; press(0, 1);
        busy_cnt = 0;
        @(negedge clk); btn_eq = 1;
        @(negedge clk); btn_eq = 0;
        wait_busy();
        repeat (9) @(negedge clk);
        alu_done = 1;
        @(negedge clk); alu_done = 0;
        repeat (3) @(negedge clk);
        chk("t4b_busy_cycles", busy_cnt, 10);
        chk("t4b_err", err, 0);
        chk("t4b_state", state, 4);

        // clear during busy
        press(2, 1);
        load_pair(8'h44, 8'h55, 2'b01);
        start_cnt = 0;
        @(negedge clk); btn_eq = 1;
        @(negedge clk); btn_eq = 0;
        wait_busy();
        @(negedge clk); btn_clr = 1;
        @(negedge clk); btn_clr = 0;
        repeat (3) @(negedge clk);
        chk("t5_still_busy", state, 3);
        alu_done = 1;
        @(negedge clk); alu_done = 0;
        repeat (3) @(negedge clk);
        chk("t5_state", state, 0);
        chk("t5_op_a", op_a, 0);
        chk("t5_op_b", op_b, 0);
        chk("t5_op_code", op_code, 0);
        chk("t5_err", err, 0);
        chk("t5_starts", start_cnt, 1);

        // reset mid-busy with eq held
        load_pair(8'h66, 8'h11, 2'b10);
        @(negedge clk); btn_eq = 1;
        wait_busy();
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk); rst = 0;
        start_cnt = 0;
        repeat (10) @(negedge clk);
        btn_eq = 0;
        repeat (5) @(negedge clk);
        chk("t6_state", state, 0);
        chk("t6_op_a", op_a, 0);
        chk("t6_op_b", op_b, 0);
        chk("t6_busy", busy, 0);
        chk("t6_err", err, 0);
        chk("t6_starts", start_cnt, 0);

        // randomized traffic, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) btn_load = ~btn_load;
            if ($urandom_range(0, 9) == 0) btn_eq   = ~btn_eq;
            if ($urandom_range(0, 29) == 0) btn_clr = ~btn_clr;
            alu_done = ($urandom_range(0, 9) == 0);
            sw       = WIDTH'($urandom);
            op_sel   = 2'($urandom);
            rst      = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        rst = 0; btn_load = 0; btn_eq = 0; btn_clr = 0; alu_done = 0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
